// File: rtl/prefix_or_pkg.sv
// Shared helpers for the pipelined prefix-OR unit.
//   clog2          : ceiling log2, used for level count and index width
//   level_of_stage : Kogge-Stone level after which pipeline stage s registers
//   WIDTH_DEF      : default vector width of the unit
package prefix_or_pkg;

    localparam int WIDTH_DEF = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Levels are spread as evenly as possible: stage s ends after
    // ceil((s+1)*L/STAGES) levels, so the last stage always ends at level L.
    function automatic int level_of_stage(input int s, input int l, input int stages);
        return ((s + 1) * l + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/por_pipe_reg.sv
// One valid/ready register slice of the prefix-OR pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   up_valid/up_ready   : upstream handshake, up_data is the offered beat
//   dn_valid/dn_ready   : downstream handshake, dn_data is the held beat
// The slice accepts whenever it is empty or its beat leaves this cycle,
// so bubbles collapse and a full pipe can pass a beat through every cycle.
module por_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
);

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;

    assign up_ready = ~vld_p0 | dn_ready;

    // --- register boundary ---
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (up_ready) begin
            vld_p0 <= up_valid;
            // Data only moves on a real transfer, so an idle input never disturbs it.
            if (up_valid) data_p0 <= up_data;
        end
    end

    assign dn_valid = vld_p0;
    assign dn_data  = data_p0;

endmodule

// File: rtl/prefix_or_pipe.sv
// Pipelined prefix-OR: out_vec[i] = |in_vec[i:0], with valid/ready on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_vec is the offered vector
//   out_valid/out_ready   : output handshake
//   out_vec               : prefix OR of the accepted vector
//   out_any               : any bit set (top bit of out_vec)
//   out_idx               : lowest set bit index of the accepted vector, 0 if none
//   sticky, clr           : sticky "a beat with out_any left the unit", cleared by clr
// Kogge-Stone levels are distributed over STAGES register slices; the final
// slice drives all out_* signals directly.
module prefix_or_pipe
    import prefix_or_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_vec,
    output logic                      out_any,
    output logic [clog2(WIDTH)-1:0]   out_idx,
    output logic                      sticky,
    input  logic                      clr
);

    localparam int L    = clog2(WIDTH);
    localparam int IDXW = L;
    localparam int DW   = WIDTH + IDXW;

    function automatic logic [IDXW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    logic [DW-1:0] d_p   [STAGES];
    logic [DW-1:0] q_p   [STAGES];
    logic          vld_p [STAGES];
    logic          rdy   [STAGES+1];

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = (s == 0) ? 0 : level_of_stage(s - 1, L, STAGES);
        localparam int HI = level_of_stage(s, L, STAGES);

        logic [WIDTH-1:0] lvl [HI-LO+1];
        logic [IDXW-1:0]  idx;
        logic             up_valid;

        // --- stage boundary: input of stage s ---
        if (s == 0) begin : g_head
            // The index is taken from the raw vector once and then rides along.
            assign lvl[0]   = in_vec;
            assign idx      = lowest_set(in_vec);
            assign up_valid = in_valid;
        end else begin : g_body
            assign lvl[0]   = q_p[s-1][WIDTH-1:0];
            assign idx      = q_p[s-1][DW-1:WIDTH];
            assign up_valid = vld_p[s-1];
        end

        // Level k: p[i] |= p[i-2^k]; the shift supplies zeros for i < 2^k.
        for (genvar k = LO; k < HI; k++) begin : g_lvl
            assign lvl[k-LO+1] = lvl[k-LO] | (lvl[k-LO] << (2 ** k));
        end

        assign d_p[s] = {idx, lvl[HI-LO]};

        // --- stage boundary: register of stage s ---
        por_pipe_reg #(.DATA_W(DW)) u_reg (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_ready (rdy[s]),
            .up_data  (d_p[s]),
            .dn_valid (vld_p[s]),
            .dn_ready (rdy[s+1]),
            .dn_data  (q_p[s])
        );
    end

    // --- stage boundary: output of last register ---
    assign out_valid = vld_p[STAGES-1];
    assign out_vec   = q_p[STAGES-1][WIDTH-1:0];
    assign out_any   = q_p[STAGES-1][WIDTH-1];
    assign out_idx   = q_p[STAGES-1][DW-1:WIDTH];

    // A set event in the same cycle as clr wins, so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) sticky <= 1'b0;
        else     sticky <= (sticky & ~clr) | (out_valid & out_ready & out_any);
    end

endmodule

// File: tb/tb_prefix_or_pipe.sv
module tb_prefix_or_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] vec;
        logic       any;
        logic [2:0] idx;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- DUT A: WIDTH=4, STAGES=2 ----------------
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_any, a_sticky, a_clr;
    logic [3:0] a_in_vec, a_out_vec, a_exp_vec;
    logic [1:0] a_out_idx, a_exp_idx;
    bit         a_exp_lat;

    prefix_or_pipe #(.WIDTH(4), .STAGES(2)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_vec(a_out_vec),
        .out_any(a_out_any), .out_idx(a_out_idx), .sticky(a_sticky), .clr(a_clr)
    );

    // ---------------- DUT B: WIDTH=8, STAGES=3 ----------------
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_any, b_sticky, b_clr;
    logic [7:0] b_in_vec, b_out_vec, b_exp_vec;
    logic [2:0] b_out_idx, b_exp_idx;
    bit         b_exp_lat;
    int         b_sent = 0;

    prefix_or_pipe #(.WIDTH(8), .STAGES(3)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
        .out_any(b_out_any), .out_idx(b_out_idx), .sticky(b_sticky), .clr(b_clr)
    );

    // Scoreboard push: expected value recorded when the input handshake completes.
    always @(negedge clk) begin
        if (!rst && a_in_valid && a_in_ready)
            qa.push_back('{vec: {4'b0, a_exp_vec}, any: a_exp_vec[3], idx: {1'b0, a_exp_idx},
                           acc: cyc, lat: a_exp_lat});
        if (!rst && b_in_valid && b_in_ready) begin
            qb.push_back('{vec: b_exp_vec, any: b_exp_vec[7], idx: b_exp_idx, acc: cyc, lat: b_exp_lat});
            b_sent++;
        end
    end

    // Monitor A
    bit         a_stall = 0;
    logic [3:0] a_pv;
    logic [1:0] a_pi;
    always @(negedge clk) begin
        #1;
        if (rst) a_stall = 0;
        else begin
            if (a_stall) begin
                check("a_hold_valid", 32'(a_out_valid), 32'(1));
                check("a_hold_vec", 32'(a_out_vec), 32'(a_pv));
                check("a_hold_idx", 32'(a_out_idx), 32'(a_pi));
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL a_unexpected_beat: got vec %0h, required no beat", a_out_vec);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    check("a_vec", 32'(a_out_vec), 32'(e.vec[3:0]));
                    check("a_any", 32'(a_out_any), 32'(e.any));
                    check("a_idx", 32'(a_out_idx), 32'(e.idx[1:0]));
                    if (e.lat) check("a_latency", 32'(cyc - e.acc), 32'(2));
                end
            end
            a_stall = a_out_valid && !a_out_ready;
            a_pv = a_out_vec;
            a_pi = a_out_idx;
        end
    end

    // Monitor B
    bit         b_stall = 0;
    logic [7:0] b_pv;
    logic [2:0] b_pi;
    always @(negedge clk) begin
        #1;
        if (rst) b_stall = 0;
        else begin
            if (b_stall) begin
                check("b_hold_valid", 32'(b_out_valid), 32'(1));
                check("b_hold_vec", 32'(b_out_vec), 32'(b_pv));
                check("b_hold_idx", 32'(b_out_idx), 32'(b_pi));
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL b_unexpected_beat: got vec %0h, required no beat", b_out_vec);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    check("b_vec", 32'(b_out_vec), 32'(e.vec));
                    check("b_any", 32'(b_out_any), 32'(e.any));
                    check("b_idx", 32'(b_out_idx), 32'(e.idx));
                    if (e.lat) check("b_latency", 32'(cyc - e.acc), 32'(3));
                end
            end
            b_stall = b_out_valid && !b_out_ready;
            b_pv = b_out_vec;
            b_pi = b_out_idx;
        end
    end

    // Reference model for B: running OR from bit 0 upward; first set bit found ascending.
    function automatic logic [7:0] pfx8(input logic [7:0] v);
        logic [7:0] r;
        logic       acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc  = acc | v[i];
            r[i] = acc;
        end
        return r;
    endfunction

    function automatic logic [2:0] low8(input logic [7:0] v);
        logic [2:0] r;
        bit         found;
        r = 3'd0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (!found && v[i]) begin
                r = 3'(i);
                found = 1;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] v, input logic [3:0] ev, input logic [1:0] ei, input bit lat);
        bit ok;
        ok = 0;
        a_in_vec = v; a_exp_vec = ev; a_exp_idx = ei; a_exp_lat = lat;
        a_in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = a_in_ready;
            tick();
        end
        a_in_valid = 1'b0;
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL a_send_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic drain_a();
        for (int i = 0; i < 100 && qa.size() != 0; i++) tick();
        tick();
        check("a_drain", 32'(qa.size()), 32'(0));
    endtask

    task automatic drain_b();
        for (int i = 0; i < 200 && qb.size() != 0; i++) tick();
        tick();
        check("b_drain", 32'(qb.size()), 32'(0));
    endtask

    logic [3:0] f_vec [3] = '{4'b0011, 4'b1000, 4'b0110};
    logic [3:0] f_exp [3] = '{4'b1111, 4'b1000, 4'b1110};
    logic [1:0] f_idx [3] = '{2'd0, 2'd3, 2'd1};
    logic [7:0] b_dir [4] = '{8'h00, 8'h80, 8'h01, 8'h28};
    int         k;
    logic [7:0] v;
    bit         seen;

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_vec = 0; a_out_ready = 1; a_clr = 0;
        a_exp_vec = 0; a_exp_idx = 0; a_exp_lat = 0;
        b_in_valid = 0; b_in_vec = 0; b_out_ready = 1; b_clr = 0;
        b_exp_vec = 0; b_exp_idx = 0; b_exp_lat = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_a_out_valid", 32'(a_out_valid), 32'(0));
        check("rst_a_out_vec", 32'(a_out_vec), 32'(0));
        check("rst_a_out_any", 32'(a_out_any), 32'(0));
        check("rst_a_out_idx", 32'(a_out_idx), 32'(0));
        check("rst_a_sticky", 32'(a_sticky), 32'(0));
        check("rst_a_in_ready", 32'(a_in_ready), 32'(1));
        check("rst_b_out_valid", 32'(b_out_valid), 32'(0));
        check("rst_b_sticky", 32'(b_sticky), 32'(0));
        tick();

        // All-zero vector leaves sticky alone
        send_a(4'b0000, 4'b0000, 2'd0, 1);
        drain_a();
        @(negedge clk);
        check("a_sticky_after_zero", 32'(a_sticky), 32'(0));
        tick();

        // 0100 -> 1100, idx 2, latency 2
        send_a(4'b0100, 4'b1100, 2'd2, 1);
        drain_a();
        @(negedge clk);
        check("a_sticky_set", 32'(a_sticky), 32'(1));
        tick();

        // clr in the same cycle as the output transfer of 0001: set wins
        send_a(4'b0001, 4'b1111, 2'd0, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (a_out_valid) seen = 1;
            else tick();
        end
        check("a_clr_wait_valid", 32'(seen), 32'(1));
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        @(negedge clk);
        check("a_sticky_set_wins", 32'(a_sticky), 32'(1));
        tick();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        @(negedge clk);
        check("a_sticky_clr", 32'(a_sticky), 32'(0));
        tick();

        // Full pipe: out_ready low, three beats offered
        a_out_ready = 1'b0;
        k = 0;
        a_in_valid = 1'b1;
        a_in_vec = f_vec[0]; a_exp_vec = f_exp[0]; a_exp_idx = f_idx[0]; a_exp_lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_in_ready) k++;
            tick();
            if (k < 3) begin
                a_in_vec = f_vec[k]; a_exp_vec = f_exp[k]; a_exp_idx = f_idx[k];
            end
        end
        @(negedge clk);
        check("a_full_accepted", 32'(k), 32'(2));
        check("a_full_in_ready", 32'(a_in_ready), 32'(0));
        tick();
        a_out_ready = 1'b1;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            if (a_in_ready) k++;
            tick();
        end
        a_in_valid = 1'b0;
        check("a_third_accepted", 32'(k), 32'(3));
        drain_a();

        // Reset with two beats in flight
        a_in_valid = 1'b1;
        a_in_vec = 4'b1010; a_exp_vec = 4'b1110; a_exp_idx = 2'd1; a_exp_lat = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        a_in_valid = 1'b0;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("a_rst_flush_valid", 32'(a_out_valid), 32'(0));
        check("a_rst_flush_vec", 32'(a_out_vec), 32'(0));
        check("a_rst_sticky", 32'(a_sticky), 32'(0));
        repeat (8) tick();

        // DUT B: unstalled stream, latency must be 3
        b_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = (i < 4) ? b_dir[i] : 8'($urandom);
            b_in_valid = 1'b1;
            b_in_vec = v; b_exp_vec = pfx8(v); b_exp_idx = low8(v); b_exp_lat = 1;
            tick();
        end
        b_in_valid = 1'b0;
        drain_b();

        // DUT B: random valid and ready
        for (int c = 0; c < 20000 && b_sent < 1020; c++) begin
            v = 8'($urandom);
            b_in_valid = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_vec = v; b_exp_vec = pfx8(v); b_exp_idx = low8(v); b_exp_lat = 0;
            tick();
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        check("b_beats_sent", 32'(b_sent >= 1020), 32'(1));
        drain_b();
        @(negedge clk);
        check("b_sticky", 32'(b_sticky), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
